// File: rtl/key_extract_pipe_if.sv
// Upstream/downstream bundle of the match-key extraction pipeline.
// The slave side is the extractor; the master side is its environment.
interface key_extract_pipe_if #(
    parameter int PHV_LEN = 6400,
    parameter int KEY_LEN = 3073,
    parameter int OFF_LEN = 672
);
    logic [PHV_LEN-1:0] phv_in;
    logic               phv_valid_in;
    logic               phv_ready_out;
    logic [OFF_LEN-1:0] key_offset_in;
    logic [KEY_LEN-1:0] key_mask_in;
    logic [PHV_LEN-1:0] phv_out;
    logic               phv_valid_out;
    logic [KEY_LEN-1:0] key_out_masked;
    logic               key_valid_out;
    logic               ready_in;

    modport master (
        output phv_in,
        output phv_valid_in,
        output key_offset_in,
        output key_mask_in,
        output ready_in,
        input  phv_ready_out,
        input  phv_out,
        input  phv_valid_out,
        input  key_out_masked,
        input  key_valid_out
    );

    modport slave (
        input  phv_in,
        input  phv_valid_in,
        input  key_offset_in,
        input  key_mask_in,
        input  ready_in,
        output phv_ready_out,
        output phv_out,
        output phv_valid_out,
        output key_out_masked,
        output key_valid_out
    );
endinterface

// File: rtl/key_extract_pipe.sv
// Two-stage PHV key extractor: per-slot container select, mask, pass-through.
// Stage A captures PHV/offsets/mask; stage B holds the masked key for lookup.
module key_extract_pipe #(
    parameter int CONT_NUM  = 64,
    parameter int KEY_SLOTS = 32,
    parameter int W6        = 48,
    parameter int W4        = 32,
    parameter int W2        = 16,
    parameter int META_LEN  = 256
) (
    input logic               clk,
    input logic               rst,
    key_extract_pipe_if.slave bus
);
    localparam int OFF_W   = $clog2(CONT_NUM);
    localparam int E_W     = OFF_W + 1;
    localparam int PHV_LEN = CONT_NUM * (W6 + W4 + W2) + META_LEN;
    localparam int KEY_LEN = KEY_SLOTS * (W6 + W4 + W2) + 1;
    localparam int OFF_LEN = 3 * KEY_SLOTS * E_W;

    localparam int B2 = META_LEN;
    localparam int B4 = B2 + CONT_NUM * W2;
    localparam int B6 = B4 + CONT_NUM * W4;

    localparam int K6 = KEY_LEN - 1;
    localparam int K4 = K6 - KEY_SLOTS * W6;
    localparam int K2 = K4 - KEY_SLOTS * W4;

    localparam int O6 = OFF_LEN - 1;
    localparam int O4 = O6 - KEY_SLOTS * E_W;
    localparam int O2 = O4 - KEY_SLOTS * E_W;

    logic [PHV_LEN-1:0] phv_a;
    logic [OFF_LEN-1:0] off_a;
    logic [KEY_LEN-1:0] mask_a;
    logic               valid_a;

    logic [PHV_LEN-1:0] phv_b;
    logic [KEY_LEN-1:0] key_b;
    logic               valid_b;

    logic               adv_b;
    logic               accept;
    logic               move;

    logic [KEY_LEN-1:0] key_raw;
    logic [E_W-1:0]     e6;
    logic [E_W-1:0]     e4;
    logic [E_W-1:0]     e2;

    function automatic logic slot_hit(input logic [E_W-1:0] e);
        return e[E_W-1] && (32'(e[OFF_W-1:0]) < 32'(CONT_NUM));
    endfunction

    function automatic int slot_idx(input logic [E_W-1:0] e);
        return int'(e[OFF_W-1:0]);
    endfunction

    assign adv_b             = ~valid_b | bus.ready_in;
    assign bus.phv_ready_out = ~valid_a | adv_b;
    assign accept            = bus.phv_valid_in & bus.phv_ready_out;
    assign move              = valid_a & adv_b;

    // Disabled or out-of-range slots leave their field at zero.
    always_comb begin
        key_raw    = '0;
        key_raw[0] = 1'b1;
        e6         = '0;
        e4         = '0;
        e2         = '0;
        for (int i = 0; i < KEY_SLOTS; i++) begin
            e6 = off_a[O6 - i*E_W -: E_W];
            e4 = off_a[O4 - i*E_W -: E_W];
            e2 = off_a[O2 - i*E_W -: E_W];
            if (slot_hit(e6)) begin
                key_raw[K6 - i*W6 -: W6] =
                    phv_a[B6 + slot_idx(e6)*W6 +: W6];
            end
            if (slot_hit(e4)) begin
                key_raw[K4 - i*W4 -: W4] =
                    phv_a[B4 + slot_idx(e4)*W4 +: W4];
            end
            if (slot_hit(e2)) begin
                key_raw[K2 - i*W2 -: W2] =
                    phv_a[B2 + slot_idx(e2)*W2 +: W2];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            phv_a  <= bus.phv_in;
            off_a  <= bus.key_offset_in;
            mask_a <= bus.key_mask_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_a <= 1'b0;
            valid_b <= 1'b0;
            phv_b   <= '0;
            key_b   <= '0;
        end else begin
            if (accept) begin
                valid_a <= 1'b1;
            end else if (move) begin
                valid_a <= 1'b0;
            end
            if (adv_b) begin
                valid_b <= valid_a;
            end
            if (move) begin
                phv_b <= phv_a;
                key_b <= key_raw & ~mask_a;
            end
        end
    end

    assign bus.phv_out        = phv_b;
    assign bus.key_out_masked = key_b;
    assign bus.phv_valid_out  = valid_b;
    assign bus.key_valid_out  = valid_b;
endmodule

// File: tb/tb_key_extract_pipe.sv
// Directed and random checks of key_extract_pipe.
// Second instance uses CONT_NUM=48 so offsets can point past the last container.
module tb_key_extract_pipe;
    localparam int PL   = 6400;
    localparam int PL48 = 4864;
    localparam int KL   = 3073;
    localparam int OL   = 672;
    localparam int R2   = 256;
    localparam int R4   = 1280;
    localparam int R6   = 3328;
    localparam int Q4   = 1024;
    localparam int Q6   = 2560;
    localparam int KF4  = 1536;
    localparam int KF2  = 512;

    typedef struct packed {
        logic [PL-1:0] p;
        logic [KL-1:0] k;
    } item_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    key_extract_pipe_if #(.PHV_LEN(PL), .KEY_LEN(KL), .OFF_LEN(OL)) bus ();
    key_extract_pipe_if #(.PHV_LEN(PL48), .KEY_LEN(KL), .OFF_LEN(OL)) bus48 ();

    key_extract_pipe u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    key_extract_pipe #(.CONT_NUM(48)) u_dut48 (
        .clk (clk),
        .rst (rst),
        .bus (bus48)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] fold_k(input logic [KL-1:0] v);
        logic [63:0] acc = '0;
        for (int i = 0; i < KL; i += 64) acc ^= 64'(v >> i);
        return acc;
    endfunction

    function automatic logic [63:0] fold_p(input logic [PL-1:0] v);
        logic [63:0] acc = '0;
        for (int i = 0; i < PL; i += 64) acc ^= 64'(v >> i);
        return acc;
    endfunction

    function automatic logic [PL-1:0] tag_phv();
        logic [PL-1:0] p = '0;
        for (int k = 0; k < 64; k++) begin
            p[R6 + k*48 +: 48] = 48'(32'h600 + k);
            p[R4 + k*32 +: 32] = 32'h400 + k;
            p[R2 + k*16 +: 16] = 16'(32'h200 + k);
        end
        for (int w = 0; w < 8; w++) p[w*32 +: 32] = 32'hC0DE_0000 + w;
        return p;
    endfunction

    function automatic logic [PL48-1:0] tag_phv48();
        logic [PL48-1:0] p = '0;
        for (int k = 0; k < 48; k++) begin
            p[Q6 + k*48 +: 48] = 48'(32'h600 + k);
            p[Q4 + k*32 +: 32] = 32'h400 + k;
            p[R2 + k*16 +: 16] = 16'(32'h200 + k);
        end
        return p;
    endfunction

    function automatic logic [OL-1:0] id_off();
        logic [OL-1:0] o = '0;
        for (int c = 0; c < 3; c++)
            for (int i = 0; i < 32; i++)
                o[OL-1 - (c*32 + i)*7 -: 7] = {1'b1, 6'(i)};
        return o;
    endfunction

    // Reference key: walk slots MSB-first with a running key pointer.
    function automatic logic [KL-1:0] ref_key(input logic [PL-1:0] p,
                                              input logic [OL-1:0] o,
                                              input logic [KL-1:0] m);
        logic [KL-1:0] k = '0;
        logic [6:0]    e;
        int            pos = KL - 1;
        int            n = 0;
        for (int i = 0; i < 32; i++, n++, pos -= 48) begin
            e = o[OL-1 - n*7 -: 7];
            if (e[6]) k[pos -: 48] = p[R6 + int'(e[5:0])*48 +: 48];
        end
        for (int i = 0; i < 32; i++, n++, pos -= 32) begin
            e = o[OL-1 - n*7 -: 7];
            if (e[6]) k[pos -: 32] = p[R4 + int'(e[5:0])*32 +: 32];
        end
        for (int i = 0; i < 32; i++, n++, pos -= 16) begin
            e = o[OL-1 - n*7 -: 7];
            if (e[6]) k[pos -: 16] = p[R2 + int'(e[5:0])*16 +: 16];
        end
        k[0] = 1'b1;
        return k & ~m;
    endfunction

    task automatic test_reset();
        bus.phv_valid_in = 0;
        bus.phv_in = '0;
        bus.key_offset_in = '0;
        bus.key_mask_in = '0;
        bus.ready_in = 1;
        bus48.phv_valid_in = 0;
        bus48.phv_in = '0;
        bus48.key_offset_in = '0;
        bus48.key_mask_in = '0;
        bus48.ready_in = 1;
        rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        n_tests++;
        if (bus.phv_valid_out !== 1'b0 || bus.key_valid_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid got %b/%b exp 0/0",
                     bus.phv_valid_out, bus.key_valid_out);
        end
        n_tests++;
        if (bus.phv_out !== '0 || bus.key_out_masked !== '0) begin
            n_fail++;
            $display("FAIL reset_data got %h/%h exp 0/0",
                     fold_p(bus.phv_out), fold_k(bus.key_out_masked));
        end
        n_tests++;
        if (bus.phv_ready_out !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready got %b exp 1", bus.phv_ready_out);
        end
    endtask

    task automatic test_basic();
        logic [PL-1:0] p = tag_phv();
        logic [OL-1:0] o = id_off();
        @(posedge clk); #1;
        bus.phv_in = p;
        bus.key_offset_in = o;
        bus.key_mask_in = '0;
        bus.phv_valid_in = 1;
        bus.ready_in = 1;
        @(posedge clk); #1;
        bus.phv_valid_in = 0;
        @(negedge clk);
        n_tests++;
        if (bus.phv_valid_out !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_early got %b exp 0", bus.phv_valid_out);
        end
        @(negedge clk);
        n_tests++;
        if (bus.phv_valid_out !== 1'b1 || bus.key_valid_out !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_valid got %b/%b exp 1/1",
                     bus.phv_valid_out, bus.key_valid_out);
        end
        n_tests++;
        if (bus.key_out_masked[KL-1 -: 48] !== 48'h0000_0000_0600) begin
            n_fail++;
            $display("FAIL basic_6b0 got %h exp 000000000600",
                     bus.key_out_masked[KL-1 -: 48]);
        end
        n_tests++;
        if (bus.key_out_masked[KF2 - 5*16 -: 16] !== 16'h0205) begin
            n_fail++;
            $display("FAIL basic_2b5 got %h exp 0205",
                     bus.key_out_masked[KF2 - 5*16 -: 16]);
        end
        n_tests++;
        if (bus.key_out_masked[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_bit0 got %b exp 1", bus.key_out_masked[0]);
        end
        n_tests++;
        if (bus.phv_out !== p) begin
            n_fail++;
            $display("FAIL basic_phv got %h exp %h",
                     fold_p(bus.phv_out), fold_p(p));
        end
        n_tests++;
        if (bus.key_out_masked !== ref_key(p, o, '0)) begin
            n_fail++;
            $display("FAIL basic_key got %h exp %h",
                     fold_k(bus.key_out_masked), fold_k(ref_key(p, o, '0)));
        end
        @(negedge clk);
        n_tests++;
        if (bus.phv_valid_out !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_pulse got %b exp 0", bus.phv_valid_out);
        end
    endtask

    task automatic test_slot_ctrl();
        logic [PL-1:0] p = tag_phv();
        logic [OL-1:0] o = id_off();
        o[OL-1 - 1*7 -: 7] = {1'b1, 6'd63};
        o[OL-1 - (32 + 3)*7 -: 7] = {1'b0, 6'd3};
        @(posedge clk); #1;
        bus.phv_in = p;
        bus.key_offset_in = o;
        bus.key_mask_in = '0;
        bus.phv_valid_in = 1;
        @(posedge clk); #1;
        bus.phv_valid_in = 0;
        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if (bus.key_out_masked[KF4 - 3*32 -: 32] !== 32'h0) begin
            n_fail++;
            $display("FAIL ctrl_4b3_off got %h exp 0",
                     bus.key_out_masked[KF4 - 3*32 -: 32]);
        end
        n_tests++;
        if (bus.key_out_masked[KF4 - 4*32 -: 32] !== 32'h404) begin
            n_fail++;
            $display("FAIL ctrl_4b4 got %h exp 404",
                     bus.key_out_masked[KF4 - 4*32 -: 32]);
        end
        n_tests++;
        if (bus.key_out_masked[KL-1 - 48 -: 48] !== 48'h63F) begin
            n_fail++;
            $display("FAIL ctrl_6b1_c63 got %h exp 63f",
                     bus.key_out_masked[KL-1 - 48 -: 48]);
        end
    endtask

    task automatic test_range();
        logic [PL48-1:0] p = tag_phv48();
        logic [OL-1:0]   o = id_off();
        o[OL-1 -: 7] = {1'b1, 6'd50};
        o[OL-1 - 1*7 -: 7] = {1'b1, 6'd47};
        o[OL-1 - 64*7 -: 7] = {1'b1, 6'd48};
        @(posedge clk); #1;
        bus48.phv_in = p;
        bus48.key_offset_in = o;
        bus48.key_mask_in = '0;
        bus48.phv_valid_in = 1;
        @(posedge clk); #1;
        bus48.phv_valid_in = 0;
        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if (bus48.phv_valid_out !== 1'b1) begin
            n_fail++;
            $display("FAIL range_valid got %b exp 1", bus48.phv_valid_out);
        end
        n_tests++;
        if (bus48.key_out_masked[KL-1 -: 48] !== 48'h0) begin
            n_fail++;
            $display("FAIL range_6b0_i50 got %h exp 0",
                     bus48.key_out_masked[KL-1 -: 48]);
        end
        n_tests++;
        if (bus48.key_out_masked[KL-1 - 48 -: 48] !== 48'h62F) begin
            n_fail++;
            $display("FAIL range_6b1_i47 got %h exp 62f",
                     bus48.key_out_masked[KL-1 - 48 -: 48]);
        end
        n_tests++;
        if (bus48.key_out_masked[KF2 -: 16] !== 16'h0) begin
            n_fail++;
            $display("FAIL range_2b0_i48 got %h exp 0",
                     bus48.key_out_masked[KF2 -: 16]);
        end
        n_tests++;
        if (bus48.key_out_masked[KF2 - 2*16 -: 16] !== 16'h0202) begin
            n_fail++;
            $display("FAIL range_2b2 got %h exp 0202",
                     bus48.key_out_masked[KF2 - 2*16 -: 16]);
        end
    endtask

    task automatic test_mask();
        logic [PL-1:0] p = tag_phv();
        logic [KL-1:0] m = '1;
        logic [KL-1:0] exp_k = '0;
        m[KF2 -: 16] = 16'h0;
        exp_k[KF2 -: 16] = 16'h0200;
        @(posedge clk); #1;
        bus.phv_in = p;
        bus.key_offset_in = id_off();
        bus.key_mask_in = m;
        bus.phv_valid_in = 1;
        @(posedge clk); #1;
        bus.phv_valid_in = 0;
        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if (bus.key_out_masked !== exp_k) begin
            n_fail++;
            $display("FAIL mask_key got %h exp %h (2b0 got %h exp 0200)",
                     fold_k(bus.key_out_masked), fold_k(exp_k),
                     bus.key_out_masked[KF2 -: 16]);
        end
        n_tests++;
        if (bus.key_out_masked[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL mask_bit0 got %b exp 0", bus.key_out_masked[0]);
        end
    endtask

    task automatic test_back_to_back();
        item_t         v[8];
        logic [OL-1:0] o = id_off();
        logic [PL-1:0] sp;
        logic [KL-1:0] sk;
        logic          stall = 0;
        logic          saw_drop = 0;
        int            sent = 0;
        int            got = 0;
        int            cyc = 0;
        for (int n = 0; n < 8; n++) begin
            v[n].p = tag_phv();
            v[n].p[R6 +: 48] = 48'(n + 1);
            v[n].p[31:0] = 32'(n);
            v[n].k = ref_key(v[n].p, o, '0);
        end
        bus.key_offset_in = o;
        bus.key_mask_in = '0;
        while (got < 8 && cyc < 60) begin
            @(posedge clk); #1;
            bus.ready_in = !(cyc >= 4 && cyc < 9);
            bus.phv_valid_in = (sent < 8);
            bus.phv_in = v[sent < 8 ? sent : 7].p;
            @(negedge clk);
            if (stall) begin
                n_tests++;
                if (bus.phv_out !== sp || bus.key_out_masked !== sk ||
                    bus.phv_valid_out !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_hold got %h/%h exp %h/%h",
                             fold_p(bus.phv_out), fold_k(bus.key_out_masked),
                             fold_p(sp), fold_k(sk));
                end
            end
            n_tests++;
            if (bus.phv_ready_out !== !((sent - got) == 2 && !bus.ready_in)) begin
                n_fail++;
                $display("FAIL b2b_ready cyc %0d got %b exp %b", cyc,
                         bus.phv_ready_out,
                         !((sent - got) == 2 && !bus.ready_in));
            end
            if (!bus.phv_ready_out) saw_drop = 1;
            stall = bus.phv_valid_out && !bus.ready_in;
            sp = bus.phv_out;
            sk = bus.key_out_masked;
            if (bus.phv_valid_out && bus.ready_in) begin
                n_tests++;
                if (bus.phv_out !== v[got].p || bus.key_out_masked !== v[got].k) begin
                    n_fail++;
                    $display("FAIL b2b_out %0d got %h exp %h", got,
                             bus.key_out_masked[KL-1 -: 48],
                             v[got].k[KL-1 -: 48]);
                end
                got++;
            end
            if (bus.phv_valid_in && bus.phv_ready_out) sent++;
            cyc++;
        end
        #1 bus.phv_valid_in = 0;
        bus.ready_in = 1;
        n_tests++;
        if (got != 8) begin
            n_fail++;
            $display("FAIL b2b_count got %0d exp 8", got);
        end
        n_tests++;
        if (saw_drop !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_drop got %b exp 1", saw_drop);
        end
    endtask

    task automatic test_random();
        item_t         q[$];
        item_t         cur;
        item_t         hd;
        logic [OL-1:0] o;
        logic [KL-1:0] m;
        logic [PL-1:0] sp;
        logic [KL-1:0] sk;
        logic          have = 0;
        logic          stall = 0;
        int            sent = 0;
        int            got = 0;
        int            cyc = 0;
        while (got < 1000 && cyc < 20000) begin
            @(posedge clk); #1;
            if (!have && sent < 1000 && $urandom_range(0, 9) < 7) begin
                for (int w = 0; w < PL/32; w++) cur.p[w*32 +: 32] = $urandom;
                for (int w = 0; w < OL/32; w++) o[w*32 +: 32] = $urandom;
                for (int w = 0; w < 96; w++)
                    m[w*32 +: 32] = $urandom & $urandom & $urandom;
                m[KL-1] = 1'($urandom_range(0, 1));
                cur.k = ref_key(cur.p, o, m);
                have = 1;
                bus.phv_in = cur.p;
                bus.key_offset_in = o;
                bus.key_mask_in = m;
            end
            bus.phv_valid_in = have;
            bus.ready_in = ($urandom_range(0, 9) < 6);
            @(negedge clk);
            if (stall) begin
                n_tests++;
                if (bus.phv_out !== sp || bus.key_out_masked !== sk ||
                    bus.phv_valid_out !== 1'b1) begin
                    n_fail++;
                    $display("FAIL rnd_hold cyc %0d got %h exp %h", cyc,
                             fold_k(bus.key_out_masked), fold_k(sk));
                end
            end
            n_tests++;
            if (bus.phv_ready_out !== !((sent - got) == 2 && !bus.ready_in)) begin
                n_fail++;
                $display("FAIL rnd_ready cyc %0d got %b exp %b", cyc,
                         bus.phv_ready_out,
                         !((sent - got) == 2 && !bus.ready_in));
            end
            stall = bus.phv_valid_out && !bus.ready_in;
            sp = bus.phv_out;
            sk = bus.key_out_masked;
            if (bus.phv_valid_out && bus.ready_in) begin
                n_tests++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rnd_extra cyc %0d got 1 exp 0 outputs", cyc);
                end else begin
                    hd = q.pop_front();
                    if (bus.phv_out !== hd.p || bus.key_out_masked !== hd.k) begin
                        n_fail++;
                        $display("FAIL rnd_out %0d got %h/%h exp %h/%h", got,
                                 fold_p(bus.phv_out),
                                 fold_k(bus.key_out_masked),
                                 fold_p(hd.p), fold_k(hd.k));
                    end
                end
                got++;
            end
            if (have && bus.phv_ready_out) begin
                q.push_back(cur);
                sent++;
                have = 0;
            end
            cyc++;
        end
        #1 bus.phv_valid_in = 0;
        bus.ready_in = 1;
        n_tests++;
        if (got != 1000 || q.size() != 0) begin
            n_fail++;
            $display("FAIL rnd_count got %0d left %0d exp 1000 left 0",
                     got, q.size());
        end
    endtask

    task automatic test_reset_flight();
        logic [PL-1:0] p = tag_phv();
        logic [OL-1:0] o = id_off();
        @(posedge clk); #1;
        bus.ready_in = 0;
        bus.phv_in = p ^ {PL{1'b1}};
        bus.key_offset_in = o;
        bus.key_mask_in = '0;
        bus.phv_valid_in = 1;
        @(posedge clk); #1;
        bus.phv_in = p ^ {{(PL-32){1'b0}}, 32'hFFFF};
        @(posedge clk); #1;
        bus.phv_valid_in = 0;
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        n_tests++;
        if (bus.phv_valid_out !== 1'b0 || bus.key_valid_out !== 1'b0) begin
            n_fail++;
            $display("FAIL rstf_valid got %b/%b exp 0/0",
                     bus.phv_valid_out, bus.key_valid_out);
        end
        n_tests++;
        if (bus.phv_out !== '0 || bus.key_out_masked !== '0) begin
            n_fail++;
            $display("FAIL rstf_data got %h/%h exp 0/0",
                     fold_p(bus.phv_out), fold_k(bus.key_out_masked));
        end
        n_tests++;
        if (bus.phv_ready_out !== 1'b1) begin
            n_fail++;
            $display("FAIL rstf_ready got %b exp 1", bus.phv_ready_out);
        end
        bus.ready_in = 1;
        @(posedge clk); #1;
        bus.phv_in = p;
        bus.phv_valid_in = 1;
        @(posedge clk); #1;
        bus.phv_valid_in = 0;
        @(negedge clk);
        n_tests++;
        if (bus.phv_valid_out !== 1'b0) begin
            n_fail++;
            $display("FAIL rstf_stale got %b exp 0", bus.phv_valid_out);
        end
        @(negedge clk);
        n_tests++;
        if (bus.phv_valid_out !== 1'b1 || bus.phv_out !== p ||
            bus.key_out_masked !== ref_key(p, o, '0)) begin
            n_fail++;
            $display("FAIL rstf_fresh got %b/%h exp 1/%h", bus.phv_valid_out,
                     fold_p(bus.phv_out), fold_p(p));
        end
        @(negedge clk);
        n_tests++;
        if (bus.phv_valid_out !== 1'b0) begin
            n_fail++;
            $display("FAIL rstf_drain got %b exp 0", bus.phv_valid_out);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_slot_ctrl();
        test_range();
        test_mask();
        test_back_to_back();
        test_random();
        test_reset_flight();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
